// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores to the data cache,
// extracts and extends load data, and holds results for write-back.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   mem_module_enable     valid instruction present; held until mem_done
//   opcode, funct3        decoded instruction controls
//   alu_result            effective address (or pass-through result)
//   store_data            rs2 value for stores
//   dcache_req_*          request channel (valid/ready, we, addr, wdata, wstrb)
//   dcache_resp_*         single-cycle load response
//   loaded_data           extended load result (0 for non-loads)
//   alu_result_out        registered alu_result for write-back
//   mem_done              stage complete, held while enable stays high
//   misaligned_fault      access not naturally aligned
//   mem_timeout           load response did not arrive within MAX_WAIT
module mem_access_stage #(
   parameter int DCACHE_DATA_W = 64,
   parameter int MAX_WAIT      = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mem_module_enable,
   input  logic [6:0]               opcode,
   input  logic [2:0]               funct3,
   input  logic [63:0]              alu_result,
   input  logic [DCACHE_DATA_W-1:0] store_data,
   output logic                     dcache_req_valid,
   input  logic                     dcache_req_ready,
   output logic                     dcache_req_we,
   output logic [63:0]              dcache_addr,
   output logic [DCACHE_DATA_W-1:0] dcache_wdata,
   output logic [7:0]               dcache_wstrb,
   input  logic                     dcache_resp_valid,
   input  logic [DCACHE_DATA_W-1:0] dcache_resp_data,
   output logic [DCACHE_DATA_W-1:0] loaded_data,
   output logic [63:0]              alu_result_out,
   output logic                     mem_done,
   output logic                     misaligned_fault,
   output logic                     mem_timeout
);

   localparam int DW = DCACHE_DATA_W;
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [2:0]     f3_q;
   logic [2:0]     a_q;
   logic [CW-1:0]  wait_cnt;
   logic [CW-1:0]  cnt_next;

   logic           is_load;
   logic           is_store;
   logic           is_mem;
   logic           misal;
   logic [2:0]     a_in;
   logic [7:0]     strb_in;
   logic [DW-1:0]  wdata_in;
   logic [DW-1:0]  raw;
   logic [DW-1:0]  ext;

   assign dcache_req_valid = (state_q == S_REQ);
   assign mem_done         = (state_q == S_DONE);

   // Decode of the incoming instruction, only meaningful in IDLE
   always_comb begin
      a_in     = alu_result[2:0];
      is_load  = (opcode == OP_LOAD);
      is_store = (opcode == OP_STORE);
      is_mem   = is_load | is_store;
      misal    = 1'b0;
      strb_in  = 8'h00;
      unique case (funct3[1:0])
         2'b00: begin
            misal   = 1'b0;
            strb_in = 8'h01 << a_in;
         end
         2'b01: begin
            misal   = a_in[0];
            strb_in = 8'h03 << a_in;
         end
         2'b10: begin
            misal   = |a_in[1:0];
            strb_in = 8'h0F << a_in;
         end
         2'b11: begin
            misal   = |a_in;
            strb_in = 8'hFF;
         end
         default: begin
            misal   = 1'b0;
            strb_in = 8'h00;
         end
      endcase
      wdata_in = store_data << {a_in, 3'b000};
   end

   // Load extraction uses the latched size and byte offset
   always_comb begin
      raw = dcache_resp_data >> {a_q, 3'b000};
      ext = raw;
      unique case (f3_q)
         3'b000: ext = {{(DW-8){raw[7]}}, raw[7:0]};
         3'b001: ext = {{(DW-16){raw[15]}}, raw[15:0]};
         3'b010: ext = {{(DW-32){raw[31]}}, raw[31:0]};
         3'b100: ext = {{(DW-8){1'b0}}, raw[7:0]};
         3'b101: ext = {{(DW-16){1'b0}}, raw[15:0]};
         3'b110: ext = {{(DW-32){1'b0}}, raw[31:0]};
         default: ext = raw;
      endcase
   end

   assign cnt_next = wait_cnt + CW'(1);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (mem_module_enable) begin
               if (!is_mem || misal) state_d = S_DONE;
               else                  state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (dcache_req_ready) begin
               state_d = dcache_req_we ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (dcache_resp_valid || cnt_next == MAX_CNT) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!mem_module_enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q          <= S_IDLE;
         f3_q             <= '0;
         a_q              <= '0;
         wait_cnt         <= '0;
         dcache_req_we    <= 1'b0;
         dcache_addr      <= '0;
         dcache_wdata     <= '0;
         dcache_wstrb     <= '0;
         loaded_data      <= '0;
         alu_result_out   <= '0;
         misaligned_fault <= 1'b0;
         mem_timeout      <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            S_IDLE: begin
               if (mem_module_enable) begin
                  f3_q           <= funct3;
                  a_q            <= a_in;
                  alu_result_out <= alu_result;
                  loaded_data    <= '0;
                  if (is_mem && misal) begin
                     misaligned_fault <= 1'b1;
                  end
                  if (is_mem && !misal) begin
                     dcache_req_we <= is_store;
                     dcache_addr   <= {alu_result[63:3], 3'b000};
                     dcache_wdata  <= is_store ? wdata_in : '0;
                     dcache_wstrb  <= strb_in;
                  end
               end
            end
            S_REQ: begin
               if (dcache_req_ready) wait_cnt <= '0;
            end
            S_WAIT: begin
               if (dcache_resp_valid) begin
                  loaded_data <= ext;
               end else if (cnt_next == MAX_CNT) begin
                  mem_timeout <= 1'b1;
                  loaded_data <= '0;
               end else begin
                  wait_cnt <= cnt_next;
               end
            end
            S_DONE: begin
               if (!mem_module_enable) begin
                  misaligned_fault <= 1'b0;
                  mem_timeout      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: scenario tasks drive the
// stage and a scoreboard compares write-back results on each mem_done.
module tb_mem_access_stage;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ADD   = 7'b0110011;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_module_enable;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [63:0] alu_result;
   logic [63:0] store_data;
   logic        dcache_req_valid;
   logic        dcache_req_ready;
   logic        dcache_req_we;
   logic [63:0] dcache_addr;
   logic [63:0] dcache_wdata;
   logic [7:0]  dcache_wstrb;
   logic        dcache_resp_valid;
   logic [63:0] dcache_resp_data;
   logic [63:0] loaded_data;
   logic [63:0] alu_result_out;
   logic        mem_done;
   logic        misaligned_fault;
   logic        mem_timeout;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk               (clk),
      .reset             (reset),
      .mem_module_enable (mem_module_enable),
      .opcode            (opcode),
      .funct3            (funct3),
      .alu_result        (alu_result),
      .store_data        (store_data),
      .dcache_req_valid  (dcache_req_valid),
      .dcache_req_ready  (dcache_req_ready),
      .dcache_req_we     (dcache_req_we),
      .dcache_addr       (dcache_addr),
      .dcache_wdata      (dcache_wdata),
      .dcache_wstrb      (dcache_wstrb),
      .dcache_resp_valid (dcache_resp_valid),
      .dcache_resp_data  (dcache_resp_data),
      .loaded_data       (loaded_data),
      .alu_result_out    (alu_result_out),
      .mem_done          (mem_done),
      .misaligned_fault  (misaligned_fault),
      .mem_timeout       (mem_timeout)
   );

   typedef struct packed {
      logic [63:0] ld;
      logic [63:0] alu;
      logic        flt;
      logic        tmo;
   } exp_t;

   exp_t sb[$];
   int   checks    = 0;
   int   passed    = 0;
   int   sb_checks = 0;
   int   sb_pass   = 0;
   logic done_prev = 1'b0;

   // Observations of the last operation, filled by run_op
   logic        o_tmo;
   logic        o_req_seen;
   logic        o_stable;
   logic        o_we;
   logic [63:0] o_addr;
   logic [63:0] o_wdata;
   logic [7:0]  o_wstrb;
   int          o_vlow;
   int          o_done_cyc;
   int          o_acc2done;

   // Scoreboard consumer: one expectation per rising mem_done
   always @(negedge clk) begin
      exp_t e;
      if (reset && mem_done && !done_prev) begin
         sb_checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_empty: got mem_done want no completion");
         end else begin
            e = sb.pop_front();
            if (loaded_data !== e.ld || alu_result_out !== e.alu ||
                misaligned_fault !== e.flt || mem_timeout !== e.tmo)
               $display("FAIL sb_result: got ld=%h alu=%h f=%b t=%b want ld=%h alu=%h f=%b t=%b",
                        loaded_data, alu_result_out, misaligned_fault,
                        mem_timeout, e.ld, e.alu, e.flt, e.tmo);
            else sb_pass++;
         end
      end
      done_prev = mem_done;
   end

   function automatic logic [63:0] model_ld(input logic [2:0] f3,
                                            input logic [2:0] a,
                                            input logic [63:0] d);
      logic [63:0] r;
      int nb;
      r  = '0;
      nb = 1 << f3[1:0];
      for (int i = 0; i < nb; i++) r[8*i +: 8] = d[8*(int'(a)+i) +: 8];
      if (!f3[2] && nb < 8 && r[8*nb-1])
         for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
      return r;
   endfunction

   // Drives one instruction; acts as a cache with ready delay rdly and
   // response delay rsp_dly (cycles after the first legal cycle, <0 = none).
   // junk asserts a bogus response in the acceptance cycle.
   task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] sd,
                         input int rdly, input int rsp_dly,
                         input logic junk, input logic [63:0] rdata);
      int n;
      o_tmo = 0; o_req_seen = 0; o_stable = 1; o_vlow = 0;
      o_done_cyc = 0; o_acc2done = 0;
      opcode = op; funct3 = f3; alu_result = addr; store_data = sd;
      mem_module_enable = 1'b1;
      n = 0;
      while (!dcache_req_valid && !mem_done && n < 400) begin
         @(posedge clk); #1; n++;
      end
      o_done_cyc = n;
      if (n >= 400) begin o_tmo = 1; return; end
      if (!dcache_req_valid) return;
      o_req_seen = 1;
      o_addr = dcache_addr; o_wdata = dcache_wdata;
      o_wstrb = dcache_wstrb; o_we = dcache_req_we;
      for (int i = 0; i < rdly; i++) begin
         if (dcache_req_valid) o_vlow++;
         if (!dcache_req_valid || dcache_addr !== o_addr ||
             dcache_wdata !== o_wdata || dcache_wstrb !== o_wstrb ||
             dcache_req_we !== o_we) o_stable = 0;
         @(posedge clk); #1;
      end
      if (!dcache_req_valid || dcache_addr !== o_addr) o_stable = 0;
      dcache_req_ready = 1'b1;
      if (junk) begin
         dcache_resp_valid = 1'b1;
         dcache_resp_data  = ~rdata;
      end
      @(posedge clk); #1;
      dcache_req_ready  = 1'b0;
      dcache_resp_valid = 1'b0;
      n = 0;
      if (!o_we && rsp_dly >= 0) begin
         repeat (rsp_dly) begin @(posedge clk); #1; n++; end
         dcache_resp_valid = 1'b1;
         dcache_resp_data  = rdata;
         @(posedge clk); #1; n++;
         dcache_resp_valid = 1'b0;
      end
      while (!mem_done && n < 400) begin @(posedge clk); #1; n++; end
      o_acc2done = n;
      if (n >= 400) o_tmo = 1;
   endtask

   task automatic finish_op();
      mem_module_enable = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({dcache_req_valid, dcache_req_we, mem_done,
           misaligned_fault, mem_timeout} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000",
                  {dcache_req_valid, dcache_req_we, mem_done,
                   misaligned_fault, mem_timeout});
      else passed++;
      checks++;
      if ({dcache_addr, dcache_wdata, dcache_wstrb,
           loaded_data, alu_result_out} !== '0)
         $display("FAIL reset_data: got a=%h w=%h s=%h l=%h r=%h want 0",
                  dcache_addr, dcache_wdata, dcache_wstrb,
                  loaded_data, alu_result_out);
      else passed++;
   endtask

   task automatic test_alu_pass();
      logic bad;
      sb.push_back('{ld: 64'h0, alu: 64'h1234, flt: 1'b0, tmo: 1'b0});
      run_op(OP_ADD, 3'b000, 64'h1234, 64'h0, 0, 0, 1'b0, 64'h0);
      checks++;
      if (o_req_seen !== 1'b0 || o_done_cyc != 1)
         $display("FAIL add_latency: got req=%b cyc=%0d want req=0 cyc=1",
                  o_req_seen, o_done_cyc);
      else passed++;
      bad = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (!mem_done || dcache_req_valid) bad = 1;
      end
      checks++;
      if (bad !== 1'b0)
         $display("FAIL add_hold: got bad=%b want 0", bad);
      else passed++;
      finish_op();
      checks++;
      if (mem_done !== 1'b0)
         $display("FAIL add_release: got done=%b want 0", mem_done);
      else passed++;
   endtask

   task automatic test_lb();
      sb.push_back('{ld: 64'hFFFFFFFF_FFFFFF80, alu: 64'h1003,
                     flt: 1'b0, tmo: 1'b0});
      run_op(OP_LOAD, 3'b000, 64'h1003, 64'h0, 0, 0, 1'b0,
             64'h00000000_80000000);
      checks++;
      if (o_tmo || o_addr !== 64'h1000 || o_we !== 1'b0 || o_acc2done != 1)
         $display("FAIL lb_req: got a=%h we=%b lat=%0d want a=1000 we=0 lat=1",
                  o_addr, o_we, o_acc2done);
      else passed++;
      finish_op();
   endtask

   task automatic test_lwu();
      sb.push_back('{ld: 64'h00000000_DEADBEEF, alu: 64'h2004,
                     flt: 1'b0, tmo: 1'b0});
      run_op(OP_LOAD, 3'b110, 64'h2004, 64'h0, 1, 2, 1'b1,
             64'hDEADBEEF_00000000);
      checks++;
      if (o_tmo || o_addr !== 64'h2000 || o_acc2done != 3)
         $display("FAIL lwu_req: got a=%h lat=%0d want a=2000 lat=3",
                  o_addr, o_acc2done);
      else passed++;
      finish_op();
   endtask

   task automatic test_store_stall();
      sb.push_back('{ld: 64'h0, alu: 64'h3006, flt: 1'b0, tmo: 1'b0});
      run_op(OP_STORE, 3'b001, 64'h3006, 64'hABCD, 3, -1, 1'b0, 64'h0);
      checks++;
      if (o_vlow != 3 || o_stable !== 1'b1)
         $display("FAIL sh_stall: got vlow=%0d stable=%b want 3 1",
                  o_vlow, o_stable);
      else passed++;
      checks++;
      if (o_wstrb !== 8'hC0 || o_wdata !== 64'hABCD0000_00000000 ||
          o_addr !== 64'h3000 || o_we !== 1'b1)
         $display("FAIL sh_req: got s=%h w=%h a=%h we=%b want c0 abcd000000000000 3000 1",
                  o_wstrb, o_wdata, o_addr, o_we);
      else passed++;
      checks++;
      if (o_tmo || o_acc2done != 0)
         $display("FAIL sh_done: got lat=%0d want 0", o_acc2done);
      else passed++;
      finish_op();
   endtask

   task automatic test_misaligned();
      sb.push_back('{ld: 64'h0, alu: 64'h4002, flt: 1'b1, tmo: 1'b0});
      run_op(OP_LOAD, 3'b010, 64'h4002, 64'h0, 0, 0, 1'b0, 64'h0);
      checks++;
      if (o_req_seen !== 1'b0 || o_done_cyc != 1 || misaligned_fault !== 1'b1)
         $display("FAIL lw_misal: got req=%b cyc=%0d f=%b want 0 1 1",
                  o_req_seen, o_done_cyc, misaligned_fault);
      else passed++;
      finish_op();
      checks++;
      if (misaligned_fault !== 1'b0 || mem_done !== 1'b0)
         $display("FAIL misal_clear: got f=%b d=%b want 0 0",
                  misaligned_fault, mem_done);
      else passed++;
   endtask

   task automatic test_reset_abort();
      int n;
      logic [63:0] d;
      opcode = OP_LOAD; funct3 = 3'b011; alu_result = 64'h8008;
      mem_module_enable = 1'b1;
      n = 0;
      while (!dcache_req_valid && n < 50) begin @(posedge clk); #1; n++; end
      checks++;
      if (!dcache_req_valid) $display("FAIL abort_req: got valid=0 want 1");
      else passed++;
      dcache_req_ready = 1'b1;
      @(posedge clk); #1;
      dcache_req_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; mem_module_enable = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      dcache_resp_valid = 1'b1; dcache_resp_data = 64'h1111_2222_3333_4444;
      @(posedge clk); #1;
      dcache_resp_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (mem_done !== 1'b0 || loaded_data !== '0 || alu_result_out !== '0 ||
          dcache_req_valid !== 1'b0 || dcache_addr !== '0)
         $display("FAIL abort_state: got d=%b l=%h r=%h v=%b a=%h want all 0",
                  mem_done, loaded_data, alu_result_out,
                  dcache_req_valid, dcache_addr);
      else passed++;
      d = {$urandom, $urandom};
      sb.push_back('{ld: d, alu: 64'h8008, flt: 1'b0, tmo: 1'b0});
      run_op(OP_LOAD, 3'b011, 64'h8008, 64'h0, 0, 1, 1'b0, d);
      checks++;
      if (o_tmo || o_addr !== 64'h8008 || o_acc2done != 2)
         $display("FAIL abort_next: got a=%h lat=%0d want a=8008 lat=2",
                  o_addr, o_acc2done);
      else passed++;
      finish_op();
   endtask

   task automatic test_back_to_back();
      logic [2:0]  aoff;
      logic [2:0]  f3;
      logic [63:0] d;
      logic [63:0] ad;
      int bad;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         f3 = 3'(i);
         unique case (f3[1:0])
            2'b00: aoff = 3'd5;
            2'b01: aoff = 3'd6;
            2'b10: aoff = 3'd4;
            default: aoff = 3'd0;
         endcase
         ad = 64'h5000 + 64'(i) * 64'h40 + 64'(aoff);
         d  = {$urandom, $urandom};
         sb.push_back('{ld: model_ld(f3, aoff, d), alu: ad,
                        flt: 1'b0, tmo: 1'b0});
         run_op(OP_LOAD, f3, ad, 64'h0, i % 2, i % 3, 1'b0, d);
         if (o_tmo || o_addr !== {ad[63:3], 3'b000}) bad++;
         finish_op();
      end
      checks++;
      if (bad != 0) $display("FAIL b2b_loads: got bad=%0d want 0", bad);
      else passed++;
      d = {$urandom, $urandom};
      sb.push_back('{ld: 64'h0, alu: 64'h7000, flt: 1'b0, tmo: 1'b0});
      run_op(OP_STORE, 3'b011, 64'h7000, d, 0, -1, 1'b0, 64'h0);
      checks++;
      if (o_wstrb !== 8'hFF || o_wdata !== d)
         $display("FAIL sd_req: got s=%h w=%h want ff %h", o_wstrb, o_wdata, d);
      else passed++;
      finish_op();
      sb.push_back('{ld: 64'h0, alu: 64'h7105, flt: 1'b0, tmo: 1'b0});
      run_op(OP_STORE, 3'b000, 64'h7105, d, 2, -1, 1'b0, 64'h0);
      checks++;
      if (o_wstrb !== 8'h20 || o_wdata !== (d << 40) || o_addr !== 64'h7100)
         $display("FAIL sb_req: got s=%h w=%h a=%h want 20 %h 7100",
                  o_wstrb, o_wdata, o_addr, d << 40);
      else passed++;
      finish_op();
   endtask

   task automatic test_timeout();
      sb.push_back('{ld: 64'h0, alu: 64'h6000, flt: 1'b0, tmo: 1'b1});
      run_op(OP_LOAD, 3'b011, 64'h6000, 64'h0, 0, -1, 1'b0, 64'h0);
      checks++;
      if (o_tmo || o_acc2done < 250 || o_acc2done > 260 || mem_timeout !== 1'b1)
         $display("FAIL timeout_lat: got lat=%0d t=%b want 250..260 1",
                  o_acc2done, mem_timeout);
      else passed++;
      finish_op();
      checks++;
      if (mem_timeout !== 1'b0 || mem_done !== 1'b0)
         $display("FAIL timeout_clear: got t=%b d=%b want 0 0",
                  mem_timeout, mem_done);
      else passed++;
   endtask

   initial begin
      reset = 1'b0;
      mem_module_enable = 1'b0;
      opcode = '0; funct3 = '0; alu_result = '0; store_data = '0;
      dcache_req_ready = 1'b0;
      dcache_resp_valid = 1'b0;
      dcache_resp_data = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      test_alu_pass();
      test_lb();
      test_lwu();
      test_store_stall();
      test_misaligned();
      test_reset_abort();
      test_back_to_back();
      test_timeout();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0)
         $display("FAIL sb_leftover: got %0d want 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed + sb_pass, checks + sb_checks);
      $finish;
   end

endmodule
